unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
- Moore FSM that sequences the counter/comparator datapath (contador_163 + comparador_85 + input register) for one round of the memory/switch-check game.
- Clears the datapath, waits for a player move, registers the switches, compares, then advances the counter or ends the round.
- Reports win/lose/timeout and exposes its state code on db_estado, which the top level feeds to a hexa7seg display.
- The top level inverts the active-high clear/load strobes for the active-low contador_163 pins.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed in ESPERA before timeout; used only with TIMEOUT_EN; must be >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; forces INICIAL.
- iniciar  in  1  level; starts or restarts a round.
- jogada  in  1  level, synchronous to clock; player has set the switches; the block edge-detects it internally.
- fim  in  1  counter rco: last address reached.
- igual  in  1  comparator equal flag for registered switches vs expected value.
- zera_c  out  1  clear counter.
- conta_c  out  1  counter enable, one cycle.
- zera_r  out  1  clear switch register.
- registra_r  out  1  load switch register, one cycle.
- pronto  out  1  round finished.
- acertou  out  1  round won.
- errou  out  1  round lost (mismatch or timeout).
- timeout  out  1  round lost by timeout; constant 0 without TIMEOUT_EN.
- db_estado  out  4  current state code.

Behaviour:
- One clock domain. Synchronous reset, active-high: state <= INICIAL, edge register <= 0, timeout counter <= 0. All outputs are 0 while reset is high and in the following INICIAL cycle. Reset overrides every other input.
- Outputs are Moore, decoded from the state register only. A strobe is high for exactly the cycles spent in its state.
- State codes and db_estado values:
  - INICIAL = 0
  - PREPARA = 1
  - ESPERA = 2
  - REGISTRA = 4
  - COMPARA = 5
  - PROXIMO = 6
  - FIM_ACERTO = A
  - FIM_TIMEOUT = D
  - FIM_ERRO = E
  - Unused codes return to INICIAL on the next clock.
- INICIAL: all outputs 0; iniciar=1 -> PREPARA, else stay.
- PREPARA: zera_c=1, zera_r=1; -> ESPERA unconditionally (1 cycle).
- ESPERA: all strobes 0; jogada rising edge -> REGISTRA, else stay.
- REGISTRA: registra_r=1; -> COMPARA (1 cycle).
- COMPARA: the registered switch value is valid this cycle.
  - igual=0 -> FIM_ERRO.
  - igual=1 and fim=1 -> FIM_ACERTO.
  - igual=1 and fim=0 -> PROXIMO.
- PROXIMO: conta_c=1; -> ESPERA (1 cycle).
- FIM_ACERTO: pronto=1, acertou=1. FIM_ERRO: pronto=1, errou=1. Both hold until iniciar=1, then -> PREPARA; a new round needs no reset.
- Edge detection: jogada_d <= jogada every cycle in every state. The edge is jogada & ~jogada_d.
  - jogada held high on entry to ESPERA does not advance the FSM; a new 0->1 transition is required.
  - An edge outside ESPERA is discarded.
- Latency, jogada edge to registra_r: 1 cycle. Edge to conta_c on a match: 3 cycles.
- iniciar is ignored in PREPARA..PROXIMO; it never aborts a round in progress.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT_CICLOS) is held at 0 outside ESPERA and increments each ESPERA cycle.
  - When it reaches TIMEOUT_CICLOS-1 with no jogada edge that cycle -> FIM_TIMEOUT: pronto=1, errou=1, timeout=1, exit on iniciar like the other end states.
  - A jogada edge in the expiry cycle wins (-> REGISTRA).
  - The counter restarts at 0 on every re-entry to ESPERA.
- Undefined: no counter logic, timeout tied 0, FIM_TIMEOUT unreachable, TIMEOUT_CICLOS unused.

Decomposition:
- Shared package holds the 4-bit state code constants, so the top-level and testbench decode db_estado identically.
- One natural sub-module: detector_borda (clock, reset, sinal -> pulso, one-cycle rising-edge pulse), reusable for the iniciar/jogada buttons elsewhere.

Test Plan:
- Reset: reset=1 with iniciar=1 held for 2 cycles -> db_estado=0, all outputs 0. Release -> PREPARA next cycle, zera_c=zera_r=1 for exactly 1 cycle.
- Winning round, 4 addresses (fim=1 on the 4th): four jogada pulses with igual=1 -> 3 conta_c pulses, then pronto=acertou=1, db_estado=A, held until iniciar.
- Mismatch on the 2nd move: igual=0 in COMPARA -> db_estado=E, errou=1, acertou=0, conta_c never asserted after that move.
- Held jogada: jogada kept at 1 through PROXIMO into ESPERA -> FSM stays at state 2 until jogada goes 0 then 1. Registra_r follows 1 cycle after the edge.
- Timeout (TIMEOUT_EN, TIMEOUT_CICLOS=8): no jogada for 8 ESPERA cycles -> db_estado=D, timeout=errou=pronto=1. An edge exactly on the 8th cycle -> REGISTRA instead.
- Restart mid-result plus reset mid-round: iniciar in FIM_ERRO -> PREPARA. Reset asserted in COMPARA -> INICIAL next cycle with all strobes 0.

Source files
------------

// File: rtl/unidade_controle_jogo_pkg.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo_pkg
// Shared definitions for the game control unit: the 4-bit state codes shown on
// db_estado (also used by the bench to decode db_estado), the bundle of Moore
// strobes, and the state -> strobe decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package unidade_controle_jogo_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

    // Moore outputs, kept together so they can be registered as one word.
    typedef struct packed {
        logic zera_c;
        logic conta_c;
        logic zera_r;
        logic registra_r;
        logic pronto;
        logic acertou;
        logic errou;
        logic timeout;
    } saidas_t;

    function automatic saidas_t decodifica(input estado_t e);
        saidas_t s;
        s = '0;
        case (e)
            PREPARA: begin
                s.zera_c = 1'b1;
                s.zera_r = 1'b1;
            end
            REGISTRA:   s.registra_r = 1'b1;
            PROXIMO:    s.conta_c    = 1'b1;
            FIM_ACERTO: begin
                s.pronto  = 1'b1;
                s.acertou = 1'b1;
            end
            FIM_ERRO: begin
                s.pronto = 1'b1;
                s.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                s.pronto  = 1'b1;
                s.errou   = 1'b1;
                s.timeout = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/unidade_controle_jogo_detector_borda.sv
// -----------------------------------------------------------------------------
// detector_borda
// One-cycle rising-edge detector for a level that is already synchronous to
// clock (player buttons). pulso = sinal & ~sinal delayed by one cycle.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  synchronous, active-high; clears the history flop
//   sinal  in  level to watch
//   pulso  out high for the first cycle sinal is seen high after being low
// -----------------------------------------------------------------------------
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_d;
    logic sinal_q;

    always_comb begin
        sinal_d = sinal;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal_d;
        end
    end

    assign pulso = sinal & ~sinal_q;

endmodule

// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
// Moore FSM sequencing the counter / comparator / switch-register datapath for
// one round of the memory game: clear, wait for a move, register switches,
// compare, then advance the counter or finish the round.
// Optional build macro: TIMEOUT_EN (adds an ESPERA cycle counter that ends the
// round in FIM_TIMEOUT after TIMEOUT_CICLOS cycles without a move).
// Ports:
//   clock, reset        clock (rising edge), synchronous active-high reset
//   iniciar             starts / restarts a round from INICIAL or an end state
//   jogada              player move level (edge-detected internally)
//   fim, igual          counter rco, comparator equal flag
//   zera_c, conta_c     counter clear, counter enable strobes
//   zera_r, registra_r  switch register clear, load strobes
//   pronto, acertou, errou, timeout   round result flags
//   db_estado           current 4-bit state code
// -----------------------------------------------------------------------------
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       fim,
    input  logic       igual,
    output logic       zera_c,
    output logic       conta_c,
    output logic       zera_r,
    output logic       registra_r,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado_d;
    estado_t estado_q;
    saidas_t saidas_d;
    saidas_t saidas_q;
    logic    borda_jogada;
    logic    expirou;

    // Edge history runs in every state, so a level already high when ESPERA
    // is entered never counts as a new move.
    detector_borda u_borda_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (borda_jogada)
    );

`ifdef TIMEOUT_EN
    localparam int               CNT_W  = $clog2(TIMEOUT_CICLOS);
    localparam logic [CNT_W-1:0] LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign expirou = (cnt_q == LIMITE);
`else
    assign expirou = 1'b0;
`endif

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:  if (iniciar) estado_d = PREPARA;
            PREPARA:  estado_d = ESPERA;
            ESPERA: begin
                // A move arriving in the expiry cycle still wins.
                if (borda_jogada) begin
                    estado_d = REGISTRA;
                end else if (expirou) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (fim) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO:  estado_d = ESPERA;
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
                if (iniciar) estado_d = PREPARA;
            end
            default:  estado_d = INICIAL;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // line up exactly with the cycles spent in each state.
        saidas_d = decodifica(estado_d);
`ifndef TIMEOUT_EN
        saidas_d.timeout = 1'b0;
`endif
    end

`ifdef TIMEOUT_EN
    // Counts only while staying in ESPERA; zero on every entry and elsewhere.
    always_comb begin
        cnt_d = '0;
        if (estado_q == ESPERA && estado_d == ESPERA) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            saidas_q <= '0;
        end else begin
            estado_q <= estado_d;
            saidas_q <= saidas_d;
        end
    end

    assign zera_c     = saidas_q.zera_c;
    assign conta_c    = saidas_q.conta_c;
    assign zera_r     = saidas_q.zera_r;
    assign registra_r = saidas_q.registra_r;
    assign pronto     = saidas_q.pronto;
    assign acertou    = saidas_q.acertou;
    assign errou      = saidas_q.errou;
    assign timeout    = saidas_q.timeout;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_jogo
// Directed and randomized rounds of the game control unit. The bench plays the
// datapath (an address counter driving fim/igual) and predicts each round's
// outcome from the list of expected matches: the first mismatching move ends
// in FIM_ERRO, otherwise the last move ends in FIM_ACERTO, with one counter
// step per matched move that is not the last.
// -----------------------------------------------------------------------------
module tb_unidade_controle_jogo;
    import unidade_controle_jogo_pkg::*;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       fim;
    logic       igual;
    logic       zera_c;
    logic       conta_c;
    logic       zera_r;
    logic       registra_r;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    int total;
    int bad;
    int addr;
    int n_end;
    int n_conta;
    bit match_tab [8];

    unidade_controle_jogo #(
        .TIMEOUT_CICLOS (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .jogada     (jogada),
        .fim        (fim),
        .igual      (igual),
        .zera_c     (zera_c),
        .conta_c    (conta_c),
        .zera_r     (zera_r),
        .registra_r (registra_r),
        .pronto     (pronto),
        .acertou    (acertou),
        .errou      (errou),
        .timeout    (timeout),
        .db_estado  (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe pattern each visible state must show:
    // {zera_c, conta_c, zera_r, registra_r, pronto, acertou, errou, timeout}
    function automatic logic [7:0] exp_outs(input logic [3:0] code);
        case (code)
            4'h1:    return 8'b1010_0000;
            4'h4:    return 8'b0001_0000;
            4'h6:    return 8'b0100_0000;
            4'hA:    return 8'b0000_1100;
            4'hE:    return 8'b0000_1010;
            4'hD:    return 8'b0000_1011;
            default: return 8'b0000_0000;
        endcase
    endfunction

    task automatic chk_state(input string tag, input logic [3:0] code);
        chk({tag, ".estado"}, {28'd0, db_estado}, {28'd0, code});
        chk({tag, ".saidas"},
            {24'd0, zera_c, conta_c, zera_r, registra_r, pronto, acertou, errou, timeout},
            {24'd0, exp_outs(code)});
    endtask

    // One clock; the datapath model reacts to the strobes present at the edge.
    task automatic step();
        logic zc;
        logic cc;
        zc = zera_c;
        cc = conta_c;
        @(posedge clock);
        #1;
        if (zc) begin
            addr = 0;
        end else if (cc) begin
            addr++;
            n_conta++;
        end
        igual = (addr < n_end) ? match_tab[addr] : 1'b1;
        fim   = (addr == n_end - 1);
    endtask

    // Plays a round of n moves; bad_at is the index of the mismatching move
    // (negative for none). Starts from INICIAL or an end state.
    task automatic play_round(input int n, input int bad_at);
        int   exp_conta;
        logic [3:0] final_code;
        n_end = n;
        for (int i = 0; i < 8; i++) match_tab[i] = (i != bad_at);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_state("prepara", 4'h1);
        n_conta = 0;
        step();
        chk_state("espera", 4'h2);
        final_code = 4'hA;
        for (int k = 0; k < n; k++) begin
            // A jogada still held from the previous move must not advance.
            repeat ($urandom_range(0, 3)) begin
                step();
                chk_state("idle", 4'h2);
            end
            if (jogada) begin
                jogada = 1'b0;
                step();
                chk_state("solta", 4'h2);
            end
            jogada = 1'b1;
            step();
            chk_state("registra", 4'h4);
            if ($urandom_range(0, 1) == 1) jogada = 1'b0;
            step();
            chk_state("compara", 4'h5);
            step();
            if (!match_tab[k]) begin
                final_code = 4'hE;
                chk_state("erro", 4'hE);
                break;
            end else if (k == n - 1) begin
                chk_state("acerto", 4'hA);
            end else begin
                chk_state("proximo", 4'h6);
                step();
                chk_state("volta", 4'h2);
            end
        end
        exp_conta = (bad_at >= 0 && bad_at < n) ? bad_at : n - 1;
        repeat ($urandom_range(1, 3)) begin
            step();
            chk_state("mantem", final_code);
        end
        chk("n_conta", n_conta, exp_conta);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        addr    = 0;
        n_end   = 1;
        n_conta = 0;
        reset   = 1'b1;
        iniciar = 1'b1;
        jogada  = 1'b0;
        fim     = 1'b0;
        igual   = 1'b0;

        // Reset wins over iniciar.
        step();
        step();
        chk_state("reset1", 4'h0);
        step();
        chk_state("reset2", 4'h0);
        iniciar = 1'b0;
        reset   = 1'b0;
        step();
        chk_state("inicial", 4'h0);

        // Winning 4-address round, then a mismatch on the second move.
        play_round(4, -1);
        play_round(4, 1);

        // Randomized rounds, each restarted from the previous end state.
        repeat (12) begin
            int n;
            int b;
            n = int'($urandom_range(1, 5));
            b = int'($urandom_range(0, n));
            if (b == n) b = -1;
            play_round(n, b);
        end

        // Reset in COMPARA, released with iniciar high.
        n_end = 4;
        for (int i = 0; i < 8; i++) match_tab[i] = 1'b1;
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_state("r.prepara", 4'h1);
        jogada = 1'b0;
        step();
        chk_state("r.espera", 4'h2);
        jogada = 1'b1;
        step();
        chk_state("r.registra", 4'h4);
        step();
        chk_state("r.compara", 4'h5);
        reset   = 1'b1;
        iniciar = 1'b1;
        step();
        chk_state("r.reset", 4'h0);
        reset = 1'b0;
        step();
        chk_state("r.prepara2", 4'h1);
        iniciar = 1'b0;
        step();
        chk_state("r.espera2", 4'h2);
        jogada = 1'b0;

`ifdef TIMEOUT_EN
        // Eight ESPERA cycles with no move end the round.
        repeat (7) begin
            step();
            chk_state("t.espera", 4'h2);
        end
        step();
        chk_state("t.timeout", 4'hD);
        step();
        chk_state("t.mantem", 4'hD);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_state("t.prepara", 4'h1);
        step();
        chk_state("t.espera2", 4'h2);
        repeat (6) begin
            step();
            chk_state("t.espera3", 4'h2);
        end
        step();
        chk_state("t.ultimo", 4'h2);
        // Edge in the expiry cycle goes to REGISTRA.
        jogada = 1'b1;
        step();
        chk_state("t.registra", 4'h4);
`else
        // Without the timeout feature ESPERA waits indefinitely.
        repeat (20) begin
            step();
            chk_state("nt.espera", 4'h2);
        end
        jogada = 1'b1;
        step();
        chk_state("nt.registra", 4'h4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
